// File: rtl/sm1118_pkg.sv
// Shared constants and types for the sm1118 soil-bot blocks (ADC frame controller,
// frequency scaling, colour-sensor counter).
package sm1118_pkg;

   localparam int ADC_FRAME_BITS = 16;
   localparam int ADC_DATA_BITS  = 12;
   localparam int ADC_CH_W       = 3;
   localparam int SCK_DIV        = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } adc_state_t;

endpackage

// File: rtl/sm1118_edge_detect.sv
// One-bit registered edge detector for a slow clock-like signal treated as data.
// o_rise/o_fall are single-cycle strobes in the i_clk domain.
module sm1118_edge_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic r_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_q <= RESET_VAL;
      else         r_q <= i_d;
   end

   assign o_q    = r_q;
   assign o_rise = i_d & ~r_q;
   assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/sm1118_adc_controller.sv
// ADC128S022 frame controller: drives CS_N/SCLK/DIN from the divided adc_sck, captures DOUT,
// and tags each result with the channel addressed in the previous frame.
// Optional channel auto-scan is enabled by defining SM1118_ADC_SCAN_EN.
module sm1118_adc_controller
   import sm1118_pkg::*;
#(
   parameter int FRAME_BITS = ADC_FRAME_BITS,
   parameter int DATA_BITS  = ADC_DATA_BITS,
   parameter int GAP_SCK    = 1
) (
   input  logic                  i_clk_50M,
   input  logic                  i_reset,
   input  logic                  i_adc_sck,
   input  logic                  i_enable,
   input  logic [ADC_CH_W-1:0]   i_ch_sel,
   input  logic                  i_adc_dout,
   output logic                  o_adc_cs_n,
   output logic                  o_adc_sclk,
   output logic                  o_adc_din,
   output logic [DATA_BITS-1:0]  o_data_out,
   output logic [ADC_CH_W-1:0]   o_data_ch,
   output logic                  o_data_valid
);

   localparam logic [4:0] BIT_END  = 5'(FRAME_BITS);
   localparam logic [3:0] GAP_LAST = 4'(GAP_SCK - 1);

   logic w_sck_q, w_rise, w_fall;

   adc_state_t r_state, w_state_nxt;
   logic [4:0]            r_bit_cnt;
   logic [3:0]            r_gap_cnt;
   logic [FRAME_BITS-2:0] r_tx_sr, w_tx_init;
   logic [DATA_BITS-1:0]  r_rx_sr;
   logic [ADC_CH_W-1:0]   r_addr, r_prev_addr, w_addr;
   logic                  r_cs_n, r_din, r_data_valid;
   logic [DATA_BITS-1:0]  r_data_out;
   logic [ADC_CH_W-1:0]   r_data_ch;
   logic                  w_start, w_tx_adv, w_done, w_gap_end, w_shift_in;

   sm1118_edge_detect #(.RESET_VAL(1'b1)) u_sck_edge (
      .i_clk   (i_clk_50M),
      .i_reset (i_reset),
      .i_d     (i_adc_sck),
      .o_q     (w_sck_q),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

`ifdef SM1118_ADC_SCAN_EN
   logic [ADC_CH_W-1:0] r_scan_ch;
   logic                w_unused_ch;

   always_ff @(posedge i_clk_50M) begin
      if (i_reset)      r_scan_ch <= '0;
      else if (w_start) r_scan_ch <= r_scan_ch + 1'b1;
   end

   assign w_addr      = r_scan_ch;
   assign w_unused_ch = ^i_ch_sel;
`else
   assign w_addr = i_ch_sel;
`endif

   // Frame word minus its MSB (always 0, driven straight onto DIN at CS fall).
   always_comb begin
      w_tx_init = '0;
      w_tx_init[FRAME_BITS-3 -: ADC_CH_W] = w_addr;
   end

   always_ff @(posedge i_clk_50M) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_tx_adv    = 1'b0;
      w_done      = 1'b0;
      w_gap_end   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fall && i_enable) begin
               w_start     = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (w_fall) begin
               if (r_bit_cnt < BIT_END) begin
                  w_tx_adv = 1'b1;
               end else begin
                  w_done      = 1'b1;
                  w_state_nxt = GAP;
               end
            end
         end
         GAP: begin
            if (w_fall && r_gap_cnt == GAP_LAST) begin
               w_gap_end   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_shift_in = (r_state == SHIFT) && w_rise && (r_bit_cnt < BIT_END);

   always_ff @(posedge i_clk_50M) begin
      if (i_reset) begin
         r_cs_n       <= 1'b1;
         r_din        <= 1'b0;
         r_bit_cnt    <= '0;
         r_gap_cnt    <= '0;
         r_tx_sr      <= '0;
         r_rx_sr      <= '0;
         r_addr       <= '0;
         r_prev_addr  <= '0;
         r_data_out   <= '0;
         r_data_ch    <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         if (w_start) begin
            r_cs_n    <= 1'b0;
            r_bit_cnt <= '0;
            r_tx_sr   <= w_tx_init;
            r_din     <= 1'b0;
            r_addr    <= w_addr;
         end
         if (w_shift_in) begin
            r_rx_sr   <= {r_rx_sr[DATA_BITS-2:0], i_adc_dout};
            r_bit_cnt <= r_bit_cnt + 5'd1;
         end
         if (w_tx_adv) begin
            r_din   <= r_tx_sr[FRAME_BITS-2];
            r_tx_sr <= {r_tx_sr[FRAME_BITS-3:0], 1'b0};
         end
         // The ADC returns the conversion of the previous frame's address.
         if (w_done) begin
            r_cs_n       <= 1'b1;
            r_din        <= 1'b0;
            r_data_out   <= r_rx_sr;
            r_data_ch    <= r_prev_addr;
            r_data_valid <= 1'b1;
            r_prev_addr  <= r_addr;
            r_gap_cnt    <= '0;
         end
         if (r_state == GAP && w_fall && !w_gap_end)
            r_gap_cnt <= r_gap_cnt + 4'd1;
      end
   end

   assign o_adc_cs_n   = r_cs_n;
   assign o_adc_sclk   = r_cs_n ? 1'b1 : w_sck_q;
   assign o_adc_din    = r_din;
   assign o_data_out   = r_data_out;
   assign o_data_ch    = r_data_ch;
   assign o_data_valid = r_data_valid;

endmodule

// File: tb/tb_sm1118_adc_controller.sv
// Bench for sm1118_adc_controller: pin-level ADC model plus scoreboard of expected codes/tags.
module tb_sm1118_adc_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        adc_sck = 1'b1;
   logic        enable = 1'b0;
   logic [2:0]  ch_sel = 3'd0;
   logic        adc_dout = 1'b0;
   logic        adc_cs_n, adc_sclk, adc_din, data_valid;
   logic [11:0] data_out;
   logic [2:0]  data_ch;

   sm1118_adc_controller dut (
      .i_clk_50M    (clk),
      .i_reset      (reset),
      .i_adc_sck    (adc_sck),
      .i_enable     (enable),
      .i_ch_sel     (ch_sel),
      .i_adc_dout   (adc_dout),
      .o_adc_cs_n   (adc_cs_n),
      .o_adc_sclk   (adc_sclk),
      .o_adc_din    (adc_din),
      .o_data_out   (data_out),
      .o_data_ch    (data_ch),
      .o_data_valid (data_valid)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // adc_sck: 8 clk high, 8 clk low, changed on negedge
   initial begin
      int div;
      div = 0;
      forever begin
         @(negedge clk);
         div++;
         if (div == 8) begin
            div = 0;
            adc_sck = ~adc_sck;
         end
      end
   end

   longint cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- ADC model + scoreboard ----------------
   logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
   int          rise_cnt = 0, bit_idx = 0, valid_cnt = 0, start_cnt = 0, sclk_viol = 0;
   longint      start_cyc = 0, prev_start_cyc = 0;
   logic [15:0] word;
   logic [11:0] code;
   logic [2:0]  frame_addr = 0, model_prev_addr = 0, cap_addr = 0, scan_ch = 0;
   logic [16:0] din_rise;
   logic [11:0] last_do;
   logic [2:0]  last_ch;
   logic [11:0] code_q[$];
   logic [14:0] exp_q[$];
   logic [2:0]  ch_log[$];

   initial forever begin
      @(negedge clk);
      if (adc_cs_n && !adc_sclk) sclk_viol++;
      if (prev_cs && !adc_cs_n) begin
         start_cnt++;
         prev_start_cyc = start_cyc;
         start_cyc = cyc;
         rise_cnt = 0;
         bit_idx = 0;
         din_rise = '0;
         cap_addr = '0;
`ifdef SM1118_ADC_SCAN_EN
         frame_addr = scan_ch;
         scan_ch = scan_ch + 3'd1;
`else
         frame_addr = ch_sel;
`endif
         if (code_q.size() > 0) code = code_q.pop_front();
         else                   code = 12'($urandom);
         // leading nibble randomised: it must never reach data_out
         word = {4'($urandom), code};
         adc_dout = word[15];
         exp_q.push_back({model_prev_addr, code});
         model_prev_addr = frame_addr;
      end else if (!adc_cs_n && !prev_sclk && adc_sclk) begin
         rise_cnt++;
         if (rise_cnt <= 16) din_rise[rise_cnt] = adc_din;
         if (rise_cnt >= 3 && rise_cnt <= 5) cap_addr = {cap_addr[1:0], adc_din};
         if (rise_cnt == 5) check("addr_bits", 32'(cap_addr), 32'(frame_addr));
      end else if (!adc_cs_n && prev_sclk && !adc_sclk) begin
         bit_idx++;
         if (bit_idx < 16) adc_dout = word[15-bit_idx];
      end
      if (data_valid) begin
         logic [14:0] e;
         valid_cnt++;
         check("valid_width", 32'(prev_valid), 32'd0);
         check("valid_latency", 32'(cyc - start_cyc), 32'd256);
         check("pending_frames", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data_out", 32'(data_out), 32'(e[11:0]));
            check("data_ch", 32'(data_ch), 32'(e[14:12]));
         end
         last_do = data_out;
         last_ch = data_ch;
         ch_log.push_back(data_ch);
      end
      prev_valid = data_valid;
      prev_cs = adc_cs_n;
      prev_sclk = adc_sclk;
   end

   task automatic wait_valids(input int n, input int budget, input string tag);
      int target, t;
      target = valid_cnt + n;
      t = 0;
      while (valid_cnt < target && t < budget) begin
         @(negedge clk); #1;
         t++;
      end
      check({tag, "_timeout"}, 32'(valid_cnt >= target), 32'd1);
   endtask

   task automatic wait_rise(input int n, input int budget, input string tag);
      int t;
      t = 0;
      while (!(rise_cnt == n && !adc_cs_n) && t < budget) begin
         @(negedge clk); #1;
         t++;
      end
      check({tag, "_timeout"}, 32'(t < budget), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
      ch_log.delete();
      model_prev_addr = 3'd0;
      scan_ch = 3'd0;
      @(negedge clk); #1;
   endtask

`ifdef SM1118_ADC_SCAN_EN
   localparam logic [2:0] F1_ADDR = 3'd0;
   localparam logic [2:0] F2_TAG  = 3'd0;
   localparam logic [2:0] F3_TAG  = 3'd1;
`else
   localparam logic [2:0] F1_ADDR = 3'd3;
   localparam logic [2:0] F2_TAG  = 3'd3;
   localparam logic [2:0] F3_TAG  = 3'd5;
`endif

   initial begin
      int v0, s0;
      // reset state
      repeat (4) @(negedge clk);
      #1;
      check("rst_cs_n", 32'(adc_cs_n), 32'd1);
      check("rst_sclk", 32'(adc_sclk), 32'd1);
      check("rst_din", 32'(adc_din), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_data_ch", 32'(data_ch), 32'd0);
      check("rst_valid", 32'(data_valid), 32'd0);
      reset = 1'b0;

      // single frame then back-to-back with boundary codes
      code_q.push_back(12'hA5C);
      code_q.push_back(12'hFFF);
      code_q.push_back(12'h000);
      ch_sel = 3'd3;
      enable = 1'b1;
      wait_valids(1, 400, "frame1");
      check("f1_code", 32'(last_do), 32'hA5C);
      check("f1_ch", 32'(last_ch), 32'd0);
      check("f1_din_r3", 32'(din_rise[3]), 32'(F1_ADDR[2]));
      check("f1_din_r4", 32'(din_rise[4]), 32'(F1_ADDR[1]));
      check("f1_din_r5", 32'(din_rise[5]), 32'(F1_ADDR[0]));
      ch_sel = 3'd5;
      wait_valids(1, 400, "frame2");
      check("f2_code", 32'(last_do), 32'hFFF);
      check("f2_ch", 32'(last_ch), 32'(F2_TAG));
      check("f2_period", 32'(start_cyc - prev_start_cyc), 32'd288);
      wait_valids(1, 400, "frame3");
      check("f3_code", 32'(last_do), 32'h000);
      check("f3_ch", 32'(last_ch), 32'(F3_TAG));
      check("f3_period", 32'(start_cyc - prev_start_cyc), 32'd288);

      // enable drop at rise 10: frame completes, no new frame
      wait_rise(10, 400, "en_drop_rise");
      enable = 1'b0;
      v0 = valid_cnt;
      s0 = start_cnt;
      repeat (700) @(negedge clk);
      #1;
      check("en_drop_valids", 32'(valid_cnt - v0), 32'd1);
      check("en_drop_starts", 32'(start_cnt - s0), 32'd0);
      check("en_drop_cs_n", 32'(adc_cs_n), 32'd1);

      // reset after 7 rises: partial frame discarded
      ch_sel = 3'd2;
      enable = 1'b1;
      wait_rise(7, 600, "rst_mid_rise");
      v0 = valid_cnt;
      do_reset();
      check("midrst_cs_n", 32'(adc_cs_n), 32'd1);
      check("midrst_valid", 32'(data_valid), 32'd0);
      check("midrst_data_out", 32'(data_out), 32'd0);
      reset = 1'b0;
      wait_valids(1, 700, "post_rst");
      check("post_rst_valids", 32'(valid_cnt - v0), 32'd1);
      check("post_rst_ch", 32'(last_ch), 32'd0);

      // random codes and channels
      for (int i = 0; i < 6; i++) begin
         ch_sel = 3'($urandom_range(0, 7));
         wait_valids(1, 400, "rand");
      end

`ifdef SM1118_ADC_SCAN_EN
      begin
         logic [2:0] scan_exp [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
         enable = 1'b0;
         do_reset();
         reset = 1'b0;
         ch_sel = 3'd6;
         enable = 1'b1;
         wait_valids(10, 3200, "scan");
         check("scan_count", 32'(ch_log.size()), 32'd10);
         for (int i = 0; i < 10 && i < ch_log.size(); i++)
            check($sformatf("scan_ch%0d", i), 32'(ch_log[i]), 32'(scan_exp[i]));
      end
`endif

      check("sclk_high_when_cs_high", 32'(sclk_viol), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
